// File: rtl/class_feature_loader.sv
`default_nettype none
// ============================================================================
// Module   : class_feature_loader
// Purpose  : Assembles a byte-stream feature frame into the NBITS-wide vector
//            driven to a bank of combinational decision trees, holds it while
//            the trees settle, then majority-votes the tree outputs and offers
//            one class decision per frame on a valid/ready port.
// Ports    : clk, rst (async, active-high)
//            s_valid/s_ready/s_data/s_last : feature byte stream, LSB byte first
//            feat                          : assembled vector to every tree
//            tree_out                      : one vote bit per tree
//            m_valid/m_ready/m_class       : decision handshake
//            frame_err                     : one-cycle pulse, frame discarded
//            m_votes (optional)            : registered popcount of the votes
// Option   : CLASS_FEATURE_LOADER_VOTE_CNT_EN adds the m_votes output.
// Revision : 1.0 - initial release
// ============================================================================
module class_feature_loader #(
    parameter int NBITS  = 51,
    parameter int NTREES = 7,
    parameter int SETTLE = 2,
    parameter int THRESH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic [NBITS-1:0]  feat,
    input  logic [NTREES-1:0] tree_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_class,
    output logic              frame_err
`ifdef CLASS_FEATURE_LOADER_VOTE_CNT_EN
    ,
    output logic [5:0]        m_votes
`endif
);

    localparam int NBYTES = (NBITS + 7) / 8;
    localparam int CW     = $clog2(NBYTES + 1);
    localparam int VW     = $clog2(NTREES + 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_VOTE   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CW-1:0]     r_byte_cnt;
    logic [3:0]        r_settle_cnt;
    logic [NBITS-1:0]  w_feat_next;
    logic [VW-1:0]     w_votes;
    logic              w_xfer;
    logic              w_last_pos;
    logic              w_good_end;
    logic              w_bad_end;
    logic              w_settle_done;
    logic              w_handshake;

    // The loader only takes bytes while assembling; this also keeps frames
    // from overlapping while a decision is outstanding.
    assign s_ready       = (r_state == ST_LOAD);
    assign w_xfer        = s_valid & s_ready;
    assign w_last_pos    = (r_byte_cnt == CW'(NBYTES - 1));
    assign w_good_end    = w_xfer & s_last & w_last_pos;
    // s_last on the wrong byte, or the final byte without s_last.
    assign w_bad_end     = w_xfer & (s_last ^ w_last_pos);
    assign w_settle_done = (r_settle_cnt == 4'(SETTLE - 1));
    assign w_handshake   = m_valid & m_ready;

    // Byte k lands on feat[8k+7:8k]; bits above NBITS-1 in the final byte
    // have no destination and are dropped.
    always_comb begin
        w_feat_next = feat;
        for (int b = 0; b < NBITS; b++) begin
            if ((b / 8) == int'(r_byte_cnt)) begin
                w_feat_next[b] = s_data[b % 8];
            end
        end
    end

    always_comb begin
        w_votes = '0;
        for (int t = 0; t < NTREES; t++) begin
            w_votes = w_votes + VW'(tree_out[t]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD:   if (w_good_end)    w_state_next = ST_SETTLE;
            ST_SETTLE: if (w_settle_done) w_state_next = ST_VOTE;
            ST_VOTE:                      w_state_next = ST_HOLD;
            ST_HOLD:   if (w_handshake)   w_state_next = ST_LOAD;
            default:                      w_state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt   <= '0;
            r_settle_cnt <= '0;
            feat         <= '0;
            m_valid      <= 1'b0;
            m_class      <= 1'b0;
            frame_err    <= 1'b0;
`ifdef CLASS_FEATURE_LOADER_VOTE_CNT_EN
            m_votes      <= '0;
`endif
        end else begin
            frame_err <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_bad_end) begin
                        frame_err  <= 1'b1;
                        r_byte_cnt <= '0;
                        feat       <= '0;
                    end else if (w_xfer) begin
                        feat         <= w_feat_next;
                        r_byte_cnt   <= w_good_end ? '0 : r_byte_cnt + 1'b1;
                        r_settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + 1'b1;
                end
                ST_VOTE: begin
                    m_valid <= 1'b1;
                    m_class <= (w_votes >= VW'(THRESH));
`ifdef CLASS_FEATURE_LOADER_VOTE_CNT_EN
                    m_votes <= 6'(w_votes);
`endif
                end
                ST_HOLD: begin
                    // feat is left alone here; the next frame's byte 0
                    // overwrites it.
                    if (w_handshake) begin
                        m_valid    <= 1'b0;
                        r_byte_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_class_feature_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_class_feature_loader
// Purpose  : Self-checking bench for class_feature_loader: table of frames
//            with expected decisions pushed to a scoreboard, plus directed
//            sequences for latency, framing errors, back-pressure, async
//            reset and gapped input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_class_feature_loader;

    localparam int NBITS  = 51;
    localparam int NTREES = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [7:0]        s_data = 8'h00;
    logic              s_last = 1'b0;
    logic [NBITS-1:0]  feat;
    logic [NTREES-1:0] tree_out = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_class;
    logic              frame_err;
`ifdef CLASS_FEATURE_LOADER_VOTE_CNT_EN
    logic [5:0]        m_votes;
`endif

    class_feature_loader #(
        .NBITS(51), .NTREES(7), .SETTLE(2), .THRESH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .feat(feat), .tree_out(tree_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
        .frame_err(frame_err)
`ifdef CLASS_FEATURE_LOADER_VOTE_CNT_EN
        , .m_votes(m_votes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [50:0] feat;
        logic        cls;
        logic [5:0]  votes;
    } exp_t;

    typedef struct packed {
        logic [55:0] bytes;
        logic [6:0]  tree;
        logic [50:0] feat;
        logic        cls;
        logic [5:0]  votes;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   ntests = 0;
    int   nfail  = 0;
    int   n_push = 0;
    int   n_dec  = 0;
    int   n_err  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #2;
            n++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!acc) begin
            ntests++;
            nfail++;
            $display("FAIL byte_accept: got s_ready=0 for 50 cycles required acceptance");
        end
    endtask

    task automatic send_frame(input logic [55:0] b, input logic [6:0] tr, input bit gap);
        tree_out = tr;
        for (int k = 0; k < 7; k++) begin
            send_byte(b[8*k +: 8], k == 6);
            if (gap && k < 6) tick();
        end
    endtask

    task automatic push_exp(input logic [50:0] f, input logic c, input logic [5:0] v);
        exp_t e;
        e.feat  = f;
        e.cls   = c;
        e.votes = v;
        sb.push_back(e);
        n_push++;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // Decision monitor: the handshake seen here completes on the next edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && frame_err) n_err++;
        if (!rst && m_valid && m_ready) begin
            n_dec++;
            if (sb.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL unexpected_decision: got m_valid=1 required no decision");
            end else begin
                e = sb.pop_front();
                check("m_class", 64'(m_class), 64'(e.cls));
                check("feat_hold", 64'(feat), 64'(e.feat));
`ifdef CLASS_FEATURE_LOADER_VOTE_CNT_EN
                check("m_votes", 64'(m_votes), 64'(e.votes));
`endif
            end
        end
    end

    initial begin : main
        int n;
        vecs[0] = '{bytes: 56'h04000000000001, tree: 7'b0001111, feat: 51'h4000000000001, cls: 1'b1, votes: 6'd4};
        vecs[1] = '{bytes: 56'h04000000000001, tree: 7'b0000111, feat: 51'h4000000000001, cls: 1'b0, votes: 6'd3};
        vecs[2] = '{bytes: 56'hFFF00FC33C5AA5, tree: 7'b1111111, feat: 51'h7F00FC33C5AA5, cls: 1'b1, votes: 6'd7};
        vecs[3] = '{bytes: 56'h00000000000000, tree: 7'b0000000, feat: 51'h0,             cls: 1'b0, votes: 6'd0};
        vecs[4] = '{bytes: 56'h08010000000080, tree: 7'b1010101, feat: 51'h10000000080,   cls: 1'b1, votes: 6'd4};
        vecs[5] = '{bytes: 56'h05BC9A78563412, tree: 7'b1100000, feat: 51'h5BC9A78563412, cls: 1'b0, votes: 6'd2};

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_class", 64'(m_class), 64'd0);
        check("rst_feat", 64'(feat), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        rst = 1'b0;
        tick();

        // Latency: m_valid 3 cycles after the last accepting edge
        m_ready = 1'b0;
        send_frame(vecs[0].bytes, vecs[0].tree, 1'b0);
        push_exp(vecs[0].feat, vecs[0].cls, vecs[0].votes);
        check("feat_assembled", 64'(feat), 64'h4000000000001);
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", 64'(n), 64'd3);
        m_ready = 1'b1;
        wait_drain();

        // Table of frames, consumer always ready
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].bytes, vecs[i].tree, 1'b0);
            push_exp(vecs[i].feat, vecs[i].cls, vecs[i].votes);
            wait_drain();
        end

        // Early s_last on byte 3
        for (int k = 0; k < 4; k++) send_byte(8'h11, k == 3);
        check("early_last_err", 64'(frame_err), 64'd1);
        check("early_last_feat", 64'(feat), 64'd0);
        check("early_last_mvalid", 64'(m_valid), 64'd0);
        tick();
        check("err_pulse_width", 64'(frame_err), 64'd0);
        // Final byte without s_last
        for (int k = 0; k < 7; k++) send_byte(8'h22, 1'b0);
        check("missing_last_err", 64'(frame_err), 64'd1);
        check("missing_last_feat", 64'(feat), 64'd0);
        send_frame(vecs[2].bytes, vecs[2].tree, 1'b0);
        push_exp(vecs[2].feat, vecs[2].cls, vecs[2].votes);
        wait_drain();

        // Back-pressure: decision held 10 cycles, byte waits for handshake
        m_ready = 1'b0;
        send_frame(vecs[5].bytes, 7'b1111000, 1'b0);
        push_exp(vecs[5].feat, 1'b1, 6'd4);
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_valid_rise", 64'(m_valid), 64'd1);
        s_valid = 1'b1;
        s_data  = 8'h55;
        s_last  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_m_valid", 64'(m_valid), 64'd1);
            check("bp_m_class", 64'(m_class), 64'd1);
            check("bp_s_ready", 64'(s_ready), 64'd0);
        end
        m_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(m_valid), 64'd0);
        check("bp_release_ready", 64'(s_ready), 64'd1);
        check("bp_byte_not_taken", 64'(feat[7:0]), 64'h12);
        tick();
        check("bp_byte_taken", 64'(feat[7:0]), 64'h55);
        s_valid = 1'b0;
        for (int k = 1; k < 7; k++) send_byte((k == 6) ? 8'h01 : 8'h00, k == 6);
        push_exp(51'h1000000000055, 1'b1, 6'd4);
        wait_drain();

        // Asynchronous reset mid-frame
        for (int k = 0; k < 5; k++) send_byte(8'hFF, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("arst_s_ready", 64'(s_ready), 64'd1);
        check("arst_m_valid", 64'(m_valid), 64'd0);
        check("arst_feat", 64'(feat), 64'd0);
        check("arst_frame_err", 64'(frame_err), 64'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick();
        send_frame(vecs[4].bytes, vecs[4].tree, 1'b0);
        push_exp(vecs[4].feat, vecs[4].cls, vecs[4].votes);
        wait_drain();

        // Gapped s_valid, top byte 0xFF keeps only three bits
        send_frame(56'hFF000000000000, 7'b0000001, 1'b1);
        check("gap_feat", 64'(feat), 64'h7000000000000);
        push_exp(51'h7000000000000, 1'b0, 6'd1);
        wait_drain();
        repeat (8) tick();
        check("gap_no_repeat", 64'(m_valid), 64'd0);

        check("decision_count", 64'(n_dec), 64'(n_push));
        check("frame_err_count", 64'(n_err), 64'd2);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/class_feature_loader.md
Name: class_feature_loader

Overview:
- Input-side counterpart to the generated combinational decision-tree classifiers: accepts feature vectors as a byte stream and assembles them into the 51-bit vector `i[50:0]` that the trees consume.
- Holds the vector stable while the trees settle, samples their 1-bit votes, reduces them by majority and hands out one class decision per frame on a valid/ready port.
- Sits between the feature-source interface and a bank of NTREES tree instances.

Parameters:
- NBITS, 51, feature vector width; frame length NBYTES = ceil(NBITS/8) = 7.
- NTREES, 7, number of tree outputs voted (1..32).
- SETTLE, 2, cycles the vector is held before votes are sampled (1..15).
- THRESH, 4, minimum number of 1-votes for a class-1 decision (1..NTREES).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_valid  in  1  input byte valid.
- s_ready  out  1  loader accepts a byte.
- s_data  in  8  feature byte; byte k carries feature bits [8k+7:8k]; LSB first.
- s_last  in  1  marks the final byte of a frame.
- feat  out  NBITS  assembled vector, wired to every tree's `i` input.
- tree_out  in  NTREES  tree `o` outputs, one bit per tree.
- m_valid  out  1  decision valid.
- m_ready  in  1  consumer accepts the decision.
- m_class  out  1  majority decision.
- frame_err  out  1  one-cycle pulse: frame discarded.

Behaviour:
- Reset (async, any state): state=LOAD, byte count=0, feat=0, s_ready=1, m_valid=0, m_class=0, frame_err=0.
- Byte transfer occurs when s_valid and s_ready are both 1 at a rising edge.

State LOAD:
- Each transfer writes the byte at the byte-count position, then the byte count increments.
- Bits beyond NBITS-1 in byte 6 are ignored; feat[50:48] = s_data[2:0] of byte 6.
- s_last on byte NBYTES-1: go to SETTLE with settle count=0; s_ready drops to 0 in the next cycle.
- s_last on an earlier byte: pulse frame_err, clear the byte count and feat, stay in LOAD.
- Byte NBYTES-1 without s_last: pulse frame_err, clear, stay in LOAD.

State SETTLE:
- feat is held constant.
- The settle count increments each cycle; after SETTLE cycles, go to VOTE.

State VOTE (one cycle):
- Popcount tree_out (width ceil(log2(NTREES+1))).
- m_class <= (count >= THRESH); m_valid <= 1; go to HOLD.

State HOLD:
- m_valid and m_class are held until m_valid and m_ready are both 1.
- On that handshake: m_valid <= 0, byte count <= 0, s_ready <= 1, state=LOAD.
- feat keeps its last value until the first byte of the next frame overwrites byte 0.

Latency and ordering:
- Latency from the accepting edge of the last byte to m_valid=1 is SETTLE+1 cycles.
- s_ready=0 in SETTLE, VOTE and HOLD, so no overlap between frames.
- m_valid never drops without a handshake.
- m_valid and m_ready both 1 with s_valid=1 on the same edge: only the output handshake occurs; a byte cannot be accepted until the next cycle, because s_ready is 0 in HOLD.
- Reset during any state aborts the frame with no frame_err pulse and no m_valid.

Optional Feature:
- Macro: CLASS_FEATURE_LOADER_VOTE_CNT_EN.
- Defined: adds output port m_votes (width 6), which carries the registered popcount captured in VOTE and is held with m_class. Reset value 0.
- Undefined: no m_votes port and no count register; the popcount is used only for the compare.

Test Plan:
1. Reset, then send 7 bytes 0x01,0x00,0x00,0x00,0x00,0x00,0x04 with s_last on the 7th -> feat=51'h4000000000001; after the last accepting edge, m_valid rises 3 cycles later (SETTLE=2).
2. Frame sent with tree_out=7'b0001111, m_ready=1 -> m_class=1, m_votes=4 (feature on); then with tree_out=7'b0000111 -> m_class=0, m_votes=3.
3. s_last asserted on byte 3 -> frame_err pulses for 1 cycle, m_valid stays 0; the next full 7-byte frame is decoded normally.
4. m_ready held 0 for 10 cycles after m_valid -> m_valid and m_class stable, s_ready=0 throughout; byte offered meanwhile is not accepted until 1 cycle after the handshake.
5. rst asserted mid-frame after byte 4 (asynchronously, between edges) -> s_ready=1, m_valid=0 and feat=0 immediately; a subsequent full frame is decoded correctly.
6. s_valid toggled 1-0-1 across the 7 bytes, with byte 6 = 0xFF -> only feat[50:48] become set from that byte; the decision is produced exactly once.
